counter_run_ctrl: RTL and testbench

- Sequencing controller for the 4-bit free-running `counter` block.
- Owns the counter's clear and enable. On `start`, clears the counter, then enables it until `count` has reached MAX_VALUE a requested number of times, or until a cycle budget expires.
- Reports completion with a `done` pulse and a sticky `err`.
- Sits between the test/control layer and the `counter` instance.

---
 rtl/counter_run_ctrl.sv | 143 ++++++++++++++
 tb/tb_counter_run_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_ctrl.sv
// Sequencing controller for a free-running counter: clears it, enables it until
// MAX_VALUE has been seen a requested number of times, or flags a timeout.
// Optional assertion checks are built when COUNTER_RUN_CTRL_ASSERT_EN is defined.
module counter_run_ctrl #(
    parameter int                 WIDTH          = 4,
    parameter logic [WIDTH-1:0]   MAX_VALUE      = {WIDTH{1'b1}},
    parameter int                 MAX_REPEATS    = 5,
    parameter int                 TIMEOUT_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       hits_req,
    input  logic             abort,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       hit_cnt
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CYC_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     REQ_MAX  = 3'(MAX_REPEATS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_req;
    logic [2:0]      r_hit_cnt;
    logic [CW-1:0]   r_cyc;

    logic            w_accept;
    logic            w_hit;
    logic [2:0]      w_hit_inc;
    logic [2:0]      w_req_clamped;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_hit     = (r_state == S_RUN) && (count_in == MAX_VALUE);
    assign w_hit_inc = r_hit_cnt + 3'd1;

    // A zero request still means "at least one hit"; oversize requests saturate.
    always_comb begin
        w_req_clamped = hits_req;
        if (hits_req == 3'd0)
            w_req_clamped = 3'd1;
        else if (hits_req > REQ_MAX)
            w_req_clamped = REQ_MAX;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_clr = 1'b1;
                busy    = 1'b1;
                w_next  = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                cnt_en = 1'b1;
                busy   = 1'b1;
                // Abort beats completion, completion beats timeout.
                if (abort)
                    w_next = S_IDLE;
                else if (w_hit && (w_hit_inc == r_req))
                    w_next = S_DONE;
                else if (r_cyc == CYC_LAST)
                    w_next = S_ERR;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                err = 1'b1;
                if (err_clr)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req     <= 3'd0;
            r_hit_cnt <= 3'd0;
            r_cyc     <= '0;
        end else if (w_accept) begin
            r_req     <= w_req_clamped;
            r_hit_cnt <= 3'd0;
            r_cyc     <= '0;
        end else if (r_state == S_RUN) begin
            r_cyc <= r_cyc + CW'(1);
            if (w_hit && !abort)
                r_hit_cnt <= w_hit_inc;
        end
    end

    assign hit_cnt = r_hit_cnt;

`ifdef COUNTER_RUN_CTRL_ASSERT_EN
    localparam logic [CW-1:0] CYC_LIM = CW'(TIMEOUT_CYCLES);

    a_clr_en_excl: assert property (@(posedge clk) disable iff (reset)
        !(cnt_clr && cnt_en));
    a_done_hits: assert property (@(posedge clk) disable iff (reset)
        done |-> (r_hit_cnt == r_req));
    a_done_pulse: assert property (@(posedge clk) disable iff (reset)
        done |=> !done);
    // r_cyc counts RUN cycles already completed in this run.
    a_run_budget: assert property (@(posedge clk) disable iff (reset)
        (r_state == S_RUN) |-> (r_cyc < CYC_LIM));
    a_hit_counts: assert property (@(posedge clk) disable iff (reset)
        w_hit |=> ((r_hit_cnt == $past(r_hit_cnt) + 3'd1) || (r_state != S_RUN)));
`endif

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench: three controllers (timeouts 100/40/48) share stimulus; each drives its own
// nominal counter. Run outcomes are predicted arithmetically and checked by a monitor.
module tb_counter_run_ctrl;

    localparam int NI = 3;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;
    localparam int K_ABORT = 3;

    typedef struct {
        int kind;
        int hits;
        int en;
        int clr;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start, abort, err_clr;
    logic [2:0] hits_req;

    logic [NI-1:0]       clr_v, en_v, busy_v, done_v, err_v;
    logic [NI-1:0][2:0]  hc_v;

    exp_t sbq[NI][$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    function automatic int to_of(int i);
        return (i == 0) ? 100 : ((i == 1) ? 40 : 48);
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int TO = (g == 0) ? 100 : ((g == 1) ? 40 : 48);
            logic [3:0] cv = 4'd0;
            counter_run_ctrl #(
                .WIDTH(4), .MAX_VALUE(4'b1111), .MAX_REPEATS(5), .TIMEOUT_CYCLES(TO)
            ) u_dut (
                .clk(clk), .reset(reset), .start(start), .hits_req(hits_req),
                .abort(abort), .err_clr(err_clr), .count_in(cv),
                .cnt_clr(clr_v[g]), .cnt_en(en_v[g]), .busy(busy_v[g]),
                .done(done_v[g]), .err(err_v[g]), .hit_cnt(hc_v[g])
            );
            always @(posedge clk) begin
                if (clr_v[g])
                    cv <= 4'd0;
                else if (en_v[g])
                    cv <= cv + 4'd1;
            end
        end
    endgenerate

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s[dut%0d]: got %0d, expected %0d (t=%0t)", nm, i, act, exp, $time);
    endtask

    task automatic check_quiet(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_outs"}, i,
                int'({clr_v[i], en_v[i], busy_v[i], done_v[i], err_v[i]}), 0);
            chk({tag, "_hit_cnt"}, i, int'(hc_v[i]), 0);
        end
    endtask

    // Monitor: one event per run end (done pulse, err rising, or busy dropping silently).
    bit pb[NI], pe[NI];
    int enc[NI], clc[NI];
    initial begin
        for (int i = 0; i < NI; i++) begin pb[i] = 0; pe[i] = 0; enc[i] = 0; clc[i] = 0; end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                int kind;
                exp_t e;
                if (reset) begin
                    pb[i] = 0; pe[i] = 0; enc[i] = 0; clc[i] = 0;
                    continue;
                end
                if (clr_v[i]) clc[i]++;
                if (en_v[i])  enc[i]++;
                kind = 0;
                if (done_v[i])
                    kind = K_DONE;
                else if (err_v[i] && !pe[i])
                    kind = K_ERR;
                else if (pb[i] && !busy_v[i] && !err_v[i])
                    kind = K_ABORT;
                if (kind != 0) begin
                    if (sbq[i].size() == 0) begin
                        chk("unexpected_event", i, kind, 0);
                    end else begin
                        e = sbq[i].pop_front();
                        chk("end_kind", i, kind, e.kind);
                        chk("hit_cnt", i, int'(hc_v[i]), e.hits);
                        chk("en_cycles", i, enc[i], e.en);
                        chk("clr_cycles", i, clc[i], e.clr);
                    end
                    enc[i] = 0;
                    clc[i] = 0;
                end
                pb[i] = busy_v[i];
                pe[i] = err_v[i];
            end
        end
    end

    // ab: -2 no abort, -1 abort in CLEAR, k>=0 abort during RUN cycle k.
    task automatic do_run(input logic [2:0] hr, input int ab);
        int   req, lastc, ed, et, nat, endc;
        exp_t e;
        req   = (hr == 0) ? 1 : ((hr > 5) ? 5 : int'(hr));
        lastc = -1;
        for (int i = 0; i < NI; i++) begin
            ed  = 16 * req - 1;
            et  = to_of(i) - 1;
            nat = (ed <= et) ? ed : et;
            e.clr = 1;
            if (ab >= -1 && ab <= nat) begin
                e.kind = K_ABORT; e.hits = (ab < 0) ? 0 : ab / 16; e.en = ab + 1; endc = ab;
            end else if (ed <= et) begin
                e.kind = K_DONE;  e.hits = req; e.en = ed + 1; endc = ed;
            end else begin
                e.kind = K_ERR;   e.hits = to_of(i) / 16; e.en = to_of(i); endc = et;
            end
            sbq[i].push_back(e);
            if (endc > lastc) lastc = endc;
        end
        @(negedge clk);
        start = 1'b1;
        hits_req = hr;
        @(negedge clk);
        // Extra start pulses land only while every controller is busy or in ERR.
        for (int c = -1; c <= lastc; c++) begin
            abort = (c == ab);
            if (c == 5 || c == 60) begin
                start = 1'b1;
                hits_req = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int i = 0; i < NI; i++)
            chk("err_after_clr", i, int'({err_v[i], busy_v[i]}), 0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; err_clr = 1'b0; hits_req = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_quiet("reset");
        @(negedge clk);
        check_quiet("idle");

        do_run(3'd3, -2);
        do_run(3'd0, -2);
        do_run(3'd7, -2);
        do_run(3'd2, 20);
        do_run(3'd4, -1);
        do_run(3'd5, 79);
        do_run(3'd1, 15);
        for (int r = 0; r < 15; r++) begin
            logic [2:0] hr;
            int ab;
            hr = 3'($urandom_range(0, 7));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 80)) - 1 : -2;
            do_run(hr, ab);
        end

        // Reset during RUN cycle 10 must drop everything on the next edge.
        @(negedge clk);
        start = 1'b1;
        hits_req = 3'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = -1; c < 10; c++) @(negedge clk);
        for (int i = 0; i < NI; i++) chk("run_active", i, int'(en_v[i]), 1);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("midrun_reset");
        reset = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");

        do_run(3'd1, -2);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk("sb_leftover", i, sbq[i].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
